ps2_rx: RTL and testbench

- PS/2 device-to-host frame receiver. Two instances, one for the keyboard port and one for the mouse port, feed peripheral_monitor's keyboard_* and mouse_* inputs.
- Synchronises and de-glitches the open-collector ps2_clk/ps2_data lines.
- Deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Emits one-cycle valid or error strobes per frame.

---
 rtl/ps2_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronises and de-glitches ps2_clk/ps2_data. Deserialises 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop). Emits one-cycle
// rx_valid / rx_error strobes per frame.
// Optional build macro PS2_RX_TIMEOUT_EN: abandons a frame whose clock stops
// for TIMEOUT_CYCLES clk cycles and reports it as an error.
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy
);

  // Reject configurations the 4-bit filter counter or the timeout cannot honour.
  if (FILTER_LEN < 2 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_rx: FILTER_LEN must be 2..15 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned FILT_W = 4;

  // Synchroniser flops; idle PS/2 lines are high, so reset to 1.
  logic clk_meta_q, clk_sync_q;
  logic data_meta_q, data_sync_q;

  // Glitch filter.
  logic              clk_filt_q, clk_filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              fall_edge;

  // Frame state.
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       frame_good;

  // Registered outputs.
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_error_q, rx_error_d;
  logic       rx_busy_q, rx_busy_d;

  // Two-flop synchronisers for both asynchronous PS/2 lines.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchroniser chain into a single flop.
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  // Filtered clock flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        clk_filt_d = ~clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end
  end

  // A falling edge is the cycle in which the filtered level is about to go 1->0.
  assign fall_edge  = clk_filt_q & ~clk_filt_d;
  // Odd parity over data plus parity bit, and a high stop bit.
  assign frame_good = data_sync_q & (^{shift_q, parity_q});

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_hit;

  // Idle-clock counter: restarts on any filtered edge and whenever idle.
  always_comb begin
    if (state_q == IDLE || clk_filt_d != clk_filt_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // Frame state machine: advances only on filtered falling edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_error_d = 1'b0;
    if (fall_edge) begin
      unique case (state_q)
        IDLE: begin
          // A high sample is a spurious edge, not a start bit.
          if (!data_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
        STOP: begin
          if (frame_good) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
`ifdef PS2_RX_TIMEOUT_EN
    end else if (state_q != IDLE && timeout_hit) begin
      // A falling edge in the same cycle takes priority over the timeout.
      state_d    = IDLE;
      shift_d    = '0;
      bit_cnt_d  = '0;
      rx_error_d = 1'b1;
`endif
    end
    rx_busy_d = (state_d != IDLE);
  end

  // Filter, frame and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_error_q <= rx_error_d;
      rx_busy_q  <= rx_busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_error = rx_error_q;
  assign rx_busy  = rx_busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench for ps2_rx. Frames are built from their line
// bits; the expected outcome (byte or error) is queued when a frame is sent
// and a monitor pops one entry per rx_valid/rx_error strobe.
// The PS/2 clock is scaled down to HALF clk cycles per phase to keep runs short.
module tb_ps2_rx;

  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT    = 100;
  localparam int unsigned HALF       = 20;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;   // rx_data expected when the strobe appears
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_data;
  int         checks;
  int         errors;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_error(rx_error),
    .rx_busy (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling clk edge, away from DUT sampling.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while the clock is high, optional short low glitch
  // in the high phase, then a full low phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cycles(HALF / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cycles(FILTER_LEN - 1);
      ps2_clk = 1'b1;
    end
    wait_cycles(HALF / 2);
    ps2_clk = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Reference model: a frame is good when stop is 1 and data+parity has an odd
  // number of ones; a good frame replaces the last received byte.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_b,
                            input int glitch_at);
    logic [10:0] bits;
    logic        par;
    bit          good;
    exp_t        e;
    par  = ((($countones(d) % 2) == 0) ? 1'b1 : 1'b0) ^ bad_par;
    bits = {stop_b, par, d, 1'b0};
    good = stop_b && ((($countones(d) + int'(par)) % 2) == 1);
    if (good) model_data = d;
    e.is_err = !good;
    e.data   = model_data;
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i], i == glitch_at);
      if (i == 4) check("busy_mid_frame", {31'b0, rx_busy}, 32'd1);
    end
    check("busy_after_frame", {31'b0, rx_busy}, 32'd0);
    check("rx_data_after_frame", {24'b0, rx_data}, {24'b0, model_data});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_data = 8'h00;
    wait_cycles(3);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("reset_rx_error", {31'b0, rx_error}, 32'd0);
    check("reset_rx_busy", {31'b0, rx_busy}, 32'd0);
    reset = 1'b0;
    wait_cycles(HALF);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (rx_valid || rx_error)) begin
      if (rx_valid && rx_error) begin
        check("valid_and_error_together", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'b0, rx_valid}, {31'b0, rx_error});
        check("unexpected_strobe_count", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_is_error", {31'b0, rx_error}, {31'b0, mon_e.is_err});
        check("strobe_rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
      end
    end
  end

  // Global bound so the run always ends.
  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    checks     = 0;
    errors     = 0;
    model_data = 8'h00;
    reset      = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    wait_cycles(2);
    apply_reset();

    // Bad parity straight after reset: rx_data must stay 0.
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    // Good frame, then the same frame with parity flipped.
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    // Parity 1 on 0x00 is correct, but stop is 0.
    send_frame(8'h00, 1'b0, 1'b0, -1);
    // Back-to-back good frames.
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);

    // Short glitch while idle, then a glitch inside the data bits.
    ps2_data = 1'b0;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(FILTER_LEN - 1);
    ps2_clk = 1'b1;
    wait_cycles(HALF);
    check("busy_after_idle_glitch", {31'b0, rx_busy}, 32'd0);
    send_frame(8'hE0, 1'b0, 1'b1, 3);

    // Reset after the 4th data bit; the partial frame must vanish.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    apply_reset();
    send_frame(8'h5A, 1'b0, 1'b1, -1);

    // Randomised frames with occasional parity/stop faults and glitches.
    for (int n = 0; n < 20; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    // Truncated frame: start bit plus 3 data bits, then the clock stays high.
`ifdef PS2_RX_TIMEOUT_EN
    e.is_err = 1'b1;
    e.data   = model_data;
    exp_q.push_back(e);
`endif
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(4 * TIMEOUT);
`ifdef PS2_RX_TIMEOUT_EN
    check("busy_after_timeout", {31'b0, rx_busy}, 32'd0);
    check("timeout_error_seen", exp_q.size(), 32'd0);
`else
    check("busy_while_stalled", {31'b0, rx_busy}, 32'd1);
    apply_reset();
`endif
    send_frame(8'h12, 1'b0, 1'b1, -1);

    // Drain: every queued expectation must have been matched.
    wait_cycles(2 * HALF);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
